// File: rtl/fft_pkg.sv
// fft_pkg: shared types and helpers for the FFT pair sequencer slice.
//   fft_seq_state_t : sequencer FSM states
//   log2()          : ceiling log2 usable in constant expressions
//   index_t         : sample index type for the default FFT length
package fft_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      GAP,
      DONE
   } fft_seq_state_t;

   function automatic int unsigned log2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r++;
      return r;
   endfunction

   localparam int unsigned FFT_SAMPLES = 8;
   localparam int unsigned FFT_LOG2    = log2(FFT_SAMPLES);

   typedef logic [FFT_LOG2-1:0] index_t;

endpackage

// File: rtl/fft_pair_sequencer_if.sv
// fft_pair_sequencer_if: control / butterfly-pair bus between the FFT sequencer
// and the butterfly datapath.
//   master (sequencer): drives busy, done, stage_num, pair_valid, idx_a, idx_b,
//                       twiddle_idx, last_in_stage; receives start, pair_ready
//   slave  (consumer) : the mirror image
interface fft_pair_sequencer_if
   import fft_pkg::*;
#(
   parameter int unsigned SAMPLES = 8
);
   localparam int unsigned LOG2 = log2(SAMPLES);
   localparam int unsigned TW_W = (LOG2 > 1) ? LOG2 - 1 : 1;

   logic            start;
   logic            busy;
   logic            done;
   logic [LOG2-1:0] stage_num;
   logic            pair_valid;
   logic            pair_ready;
   logic [LOG2-1:0] idx_a;
   logic [LOG2-1:0] idx_b;
   logic [TW_W-1:0] twiddle_idx;
   logic            last_in_stage;

   modport master (
      input  start, pair_ready,
      output busy, done, stage_num, pair_valid, idx_a, idx_b, twiddle_idx, last_in_stage
   );

   modport slave (
      output start, pair_ready,
      input  busy, done, stage_num, pair_valid, idx_a, idx_b, twiddle_idx, last_in_stage
   );

endinterface

// File: rtl/fft_index_gen.sv
// fft_index_gen: combinational map from loop counters (stage, l, j) to a
// radix-2 butterfly pair.
//   stage_i, l_i, j_i : loop counters, LOG2+1 bits wide
//   idx_a_o           : l + j
//   idx_b_o           : l + j + span, span = 1 << stage
//   twiddle_idx_o     : j << (LOG2-1-stage)
//   last_in_stage_o   : (l, j) is the final pair of the stage
module fft_index_gen
   import fft_pkg::*;
#(
   parameter  int unsigned SAMPLES = 8,
   localparam int unsigned LOG2    = log2(SAMPLES),
   localparam int unsigned CW      = LOG2 + 1,
   localparam int unsigned TW_W    = (LOG2 > 1) ? LOG2 - 1 : 1
) (
   input  logic [CW-1:0]   stage_i,
   input  logic [CW-1:0]   l_i,
   input  logic [CW-1:0]   j_i,
   output logic [LOG2-1:0] idx_a_o,
   output logic [LOG2-1:0] idx_b_o,
   output logic [TW_W-1:0] twiddle_idx_o,
   output logic            last_in_stage_o
);

   logic [CW-1:0] span;
   logic [CW-1:0] shamt;

   always_comb begin
      span            = CW'(1) << stage_i;
      shamt           = CW'(LOG2 - 1) - stage_i;
      idx_a_o         = LOG2'(l_i + j_i);
      idx_b_o         = LOG2'(l_i + j_i + span);
      twiddle_idx_o   = TW_W'(j_i << shamt);
      last_in_stage_o = (j_i == span - CW'(1)) && ((l_i + (span << 1)) == CW'(SAMPLES));
   end

endmodule

// File: rtl/fft_pair_sequencer.sv
// fft_pair_sequencer: walks every stage of a radix-2 in-place FFT and issues
// one butterfly index pair per accepted valid/ready handshake.
//   clk   : clock, all state on rising edge
//   rst_n : synchronous active-low reset
//   bus   : fft_pair_sequencer_if.master
//             start -> busy/done, stage_num,
//             pair_valid/pair_ready handshake carrying idx_a, idx_b,
//             twiddle_idx, last_in_stage
// Parameters: SAMPLES (FFT length, power of two >= 2), GAP_CYCLES (inter-stage
// drain length).
// Build option: define FFT_SEQ_STAGE_GAP_EN to insert GAP_CYCLES idle cycles
// between stages; otherwise stages run back-to-back.
module fft_pair_sequencer
   import fft_pkg::*;
#(
   parameter int unsigned SAMPLES    = 8,
   parameter int unsigned GAP_CYCLES = 2
) (
   input logic                  clk,
   input logic                  rst_n,
   fft_pair_sequencer_if.master bus
);

   localparam int unsigned LOG2 = log2(SAMPLES);
   localparam int unsigned CW   = LOG2 + 1;
   localparam int unsigned TW_W = (LOG2 > 1) ? LOG2 - 1 : 1;
   localparam int unsigned GW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [CW-1:0] LAST_STAGE = CW'(LOG2 - 1);

`ifdef FFT_SEQ_STAGE_GAP_EN
   localparam bit GAP_EN = (GAP_CYCLES != 0);
`else
   localparam bit GAP_EN = 1'b0;
`endif

   fft_seq_state_t state_q;
   logic [CW-1:0]  stage_q, l_q, j_q;
   logic [CW-1:0]  stage_d, l_d, j_d;
   logic [CW-1:0]  span;
   logic [GW-1:0]  gap_q;

   logic            busy_q, done_q, valid_q, last_q;
   logic [LOG2-1:0] stage_num_q, idx_a_q, idx_b_q;
   logic [TW_W-1:0] tw_q;

   logic [LOG2-1:0] gen_a, gen_b;
   logic [TW_W-1:0] gen_tw;
   logic            gen_last;
   logic            fire;
   logic            xform_end;

   assign fire      = valid_q & bus.pair_ready;
   // last_q flags the pair currently presented, so it already marks stage end.
   assign xform_end = last_q && (stage_q == LAST_STAGE);

   // Next loop position; only advances in RUN so IDLE feeds (0,0,0) to the
   // index generator and the first pair can be registered on start.
   always_comb begin
      span    = CW'(1) << stage_q;
      stage_d = stage_q;
      l_d     = l_q;
      j_d     = j_q;
      if (state_q == RUN) begin
         if (j_q == span - CW'(1)) begin
            j_d = '0;
            if ((l_q + (span << 1)) == CW'(SAMPLES)) begin
               l_d     = '0;
               stage_d = stage_q + CW'(1);
            end else begin
               l_d = l_q + (span << 1);
            end
         end else begin
            j_d = j_q + CW'(1);
         end
      end
   end

   fft_index_gen #(
      .SAMPLES (SAMPLES)
   ) u_index_gen (
      .stage_i         (stage_d),
      .l_i             (l_d),
      .j_i             (j_d),
      .idx_a_o         (gen_a),
      .idx_b_o         (gen_b),
      .twiddle_idx_o   (gen_tw),
      .last_in_stage_o (gen_last)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         stage_q     <= '0;
         l_q         <= '0;
         j_q         <= '0;
         gap_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
         stage_num_q <= '0;
         idx_a_q     <= '0;
         idx_b_q     <= '0;
         tw_q        <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_q     <= RUN;
                  busy_q      <= 1'b1;
                  valid_q     <= 1'b1;
                  stage_num_q <= '0;
                  idx_a_q     <= gen_a;
                  idx_b_q     <= gen_b;
                  tw_q        <= gen_tw;
                  last_q      <= gen_last;
               end
            end
            RUN: begin
               if (fire) begin
                  if (xform_end) begin
                     state_q     <= DONE;
                     stage_q     <= '0;
                     l_q         <= '0;
                     j_q         <= '0;
                     busy_q      <= 1'b0;
                     done_q      <= 1'b1;
                     valid_q     <= 1'b0;
                     last_q      <= 1'b0;
                     stage_num_q <= '0;
                     idx_a_q     <= '0;
                     idx_b_q     <= '0;
                     tw_q        <= '0;
                  end else begin
                     stage_q     <= stage_d;
                     l_q         <= l_d;
                     j_q         <= j_d;
                     stage_num_q <= LOG2'(stage_d);
                     idx_a_q     <= gen_a;
                     idx_b_q     <= gen_b;
                     tw_q        <= gen_tw;
                     last_q      <= gen_last;
                     if (last_q && GAP_EN) begin
                        state_q <= GAP;
                        valid_q <= 1'b0;
                        gap_q   <= GW'(GAP_CYCLES - 1);
                     end
                  end
               end
            end
            GAP: begin
               // Next stage's first pair is already loaded; only valid is held off.
               if (gap_q == '0) begin
                  state_q <= RUN;
                  valid_q <= 1'b1;
               end else begin
                  gap_q <= gap_q - GW'(1);
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.stage_num     = stage_num_q;
   assign bus.pair_valid    = valid_q;
   assign bus.idx_a         = idx_a_q;
   assign bus.idx_b         = idx_b_q;
   assign bus.twiddle_idx   = tw_q;
   assign bus.last_in_stage = last_q;

endmodule

// File: tb/tb_fft_pair_sequencer.sv
module tb_fft_pair_sequencer;

   localparam int GAPC = 2;
`ifdef FFT_SEQ_STAGE_GAP_EN
   localparam int GAP_ON = 1;
`else
   localparam int GAP_ON = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_r;
   logic        ready_r;
   int unsigned sel;
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   fft_pair_sequencer_if #(.SAMPLES(8))  if8  ();
   fft_pair_sequencer_if #(.SAMPLES(2))  if2  ();
   fft_pair_sequencer_if #(.SAMPLES(16)) if16 ();

   fft_pair_sequencer #(.SAMPLES(8), .GAP_CYCLES(GAPC)) u8 (
      .clk(clk), .rst_n(rst_n), .bus(if8.master));
   fft_pair_sequencer #(.SAMPLES(2), .GAP_CYCLES(GAPC)) u2 (
      .clk(clk), .rst_n(rst_n), .bus(if2.master));
   fft_pair_sequencer #(.SAMPLES(16), .GAP_CYCLES(GAPC)) u16 (
      .clk(clk), .rst_n(rst_n), .bus(if16.master));

   assign if8.start       = start_r && (sel == 0);
   assign if8.pair_ready  = ready_r && (sel == 0);
   assign if2.start       = start_r && (sel == 1);
   assign if2.pair_ready  = ready_r && (sel == 1);
   assign if16.start      = start_r && (sel == 2);
   assign if16.pair_ready = ready_r && (sel == 2);

   logic       o_busy, o_done, o_valid, o_last;
   logic [3:0] o_stage, o_a, o_b, o_tw;

   always_comb begin
      o_busy = 1'b0; o_done = 1'b0; o_valid = 1'b0; o_last = 1'b0;
      o_stage = '0; o_a = '0; o_b = '0; o_tw = '0;
      case (sel)
         0: begin
            o_busy = if8.busy; o_done = if8.done; o_valid = if8.pair_valid;
            o_last = if8.last_in_stage; o_stage = 4'(if8.stage_num);
            o_a = 4'(if8.idx_a); o_b = 4'(if8.idx_b); o_tw = 4'(if8.twiddle_idx);
         end
         1: begin
            o_busy = if2.busy; o_done = if2.done; o_valid = if2.pair_valid;
            o_last = if2.last_in_stage; o_stage = 4'(if2.stage_num);
            o_a = 4'(if2.idx_a); o_b = 4'(if2.idx_b); o_tw = 4'(if2.twiddle_idx);
         end
         2: begin
            o_busy = if16.busy; o_done = if16.done; o_valid = if16.pair_valid;
            o_last = if16.last_in_stage; o_stage = 4'(if16.stage_num);
            o_a = 4'(if16.idx_a); o_b = 4'(if16.idx_b); o_tw = 4'(if16.twiddle_idx);
         end
         default: ;
      endcase
   end

   // Reference: the full pair list of a transform, straight from the loop nest.
   typedef struct {
      int a;
      int b;
      int tw;
      int stage;
      int last;
   } pair_t;

   pair_t exp_q[$];

   function automatic int lg(input int n);
      int r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic int exp_gaps(input int n);
      return GAP_ON * GAPC * (lg(n) - 1);
   endfunction

   task automatic build(input int n);
      int k = lg(n);
      exp_q.delete();
      for (int s = 0; s < k; s++) begin
         int span = 1 << s;
         int cnt  = 0;
         for (int l = 0; l < n; l += 2 * span) begin
            for (int j = 0; j < span; j++) begin
               pair_t p;
               cnt++;
               p.a = l + j;
               p.b = l + j + span;
               p.tw = j << (k - 1 - s);
               p.stage = s;
               p.last = (cnt == n / 2) ? 1 : 0;
               exp_q.push_back(p);
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, 32'(o_valid), 0);
      chk({tag, "_busy"},  32'(o_busy), 0);
      chk({tag, "_done"},  32'(o_done), 0);
      chk({tag, "_last"},  32'(o_last), 0);
      chk({tag, "_stage"}, 32'(o_stage), 0);
      chk({tag, "_a"},     32'(o_a), 0);
      chk({tag, "_b"},     32'(o_b), 0);
      chk({tag, "_tw"},    32'(o_tw), 0);
   endtask

   // One complete transform on the selected DUT with pct% ready probability.
   task automatic run_xform(input int n, input int pct, input bit inject, input int exp_cycles);
      int idx = 0;
      int cyc = 0;
      int lowcyc = 0;
      int total;
      bit injected = 1'b0;
      bit fire;
      build(n);
      total = exp_q.size();
      ready_r = ($urandom_range(0, 99) < pct);
      start_r = 1'b1;
      step();
      start_r = 1'b0;
      cyc = 1;
      chk("busy_after_start", 32'(o_busy), 1);
      chk("valid_after_start", 32'(o_valid), 1);
      while (idx < total && cyc < 4000) begin
         chk("busy_run", 32'(o_busy), 1);
         chk("done_run", 32'(o_done), 0);
         chk("stage_num", 32'(o_stage), exp_q[idx].stage);
         if (o_valid) begin
            chk("idx_a", 32'(o_a), exp_q[idx].a);
            chk("idx_b", 32'(o_b), exp_q[idx].b);
            chk("twiddle", 32'(o_tw), exp_q[idx].tw);
            chk("last_in_stage", 32'(o_last), exp_q[idx].last);
         end else begin
            lowcyc++;
         end
         fire = o_valid && ready_r;
         if (inject && !injected && exp_q[idx].stage == 1) begin
            start_r = 1'b1;
            injected = 1'b1;
         end
         if (fire) idx++;
         step();
         start_r = 1'b0;
         cyc++;
         ready_r = ($urandom_range(0, 99) < pct);
      end
      chk("pairs_completed", idx, total);
      chk("done_pulse", 32'(o_done), 1);
      chk("busy_at_done", 32'(o_busy), 0);
      chk("valid_at_done", 32'(o_valid), 0);
      chk("stage_at_done", 32'(o_stage), 0);
      chk("gap_cycles", lowcyc, exp_gaps(n));
      if (exp_cycles > 0) chk("cycles_to_done", cyc, exp_cycles);
      if (inject) start_r = 1'b1;
      step();
      start_r = 1'b0;
      chk("done_cleared", 32'(o_done), 0);
      chk("busy_idle", 32'(o_busy), 0);
      chk("valid_idle", 32'(o_valid), 0);
      step();
      chk("still_idle_valid", 32'(o_valid), 0);
      chk("still_idle_busy", 32'(o_busy), 0);
   endtask

   initial begin
      int fires;
      int guard;
      rst_n = 1'b0;
      start_r = 1'b0;
      ready_r = 1'b0;
      sel = 0;
      repeat (3) step();
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         chk_all_zero("reset");
      end
      rst_n = 1'b1;
      step();

      // SAMPLES=8, always ready
      sel = 0;
      run_xform(8, 100, 1'b0, 12 + exp_gaps(8) + 1);
      // SAMPLES=8, random backpressure
      run_xform(8, 50, 1'b0, 0);
      run_xform(8, 50, 1'b0, 0);

      // reset after the 5th fire
      ready_r = 1'b1;
      start_r = 1'b1;
      step();
      start_r = 1'b0;
      fires = 0;
      guard = 0;
      while (fires < 5 && guard < 50) begin
         if (o_valid && ready_r) fires++;
         step();
         guard++;
      end
      chk("fires_before_reset", fires, 5);
      rst_n = 1'b0;
      step();
      chk_all_zero("midreset");
      rst_n = 1'b1;
      repeat (4) begin
         step();
         chk("no_pair_after_reset", 32'(o_valid), 0);
         chk("no_done_after_reset", 32'(o_done), 0);
      end
      run_xform(8, 100, 1'b0, 12 + exp_gaps(8) + 1);

      // start while busy and during done: ignored
      run_xform(8, 100, 1'b1, 12 + exp_gaps(8) + 1);
      run_xform(8, 100, 1'b0, 12 + exp_gaps(8) + 1);

      // SAMPLES=2
      sel = 1;
      #1;
      run_xform(2, 100, 1'b0, 2);
      run_xform(2, 50, 1'b0, 0);

      // SAMPLES=16
      sel = 2;
      #1;
      run_xform(16, 100, 1'b0, 32 + exp_gaps(16) + 1);
      run_xform(16, 50, 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
